// File: rtl/dmem_ctrl.sv
// dmem_ctrl: BRAM word store with byte-enable writes, clear engine and a timed peripheral port.
// Define DMEM_PARITY_EN to add per-lane even parity storage and the par_inject port.
module dmem_ctrl #(
  parameter int         DATA_W      = 32,
  parameter int         DEPTH       = 512,
  parameter int         AW          = 9,
  parameter logic [2:0] PER_SEL     = 3'd4,
  parameter int         PER_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_PARITY_EN
  input  logic                par_inject,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                per_req,
  output logic                per_we,
  output logic [DATA_W/8-1:0] per_be,
  output logic [31:0]         per_addr,
  output logic [DATA_W-1:0]   per_wdata,
  input  logic                per_ack,
  input  logic [DATA_W-1:0]   per_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(PER_TIMEOUT + 1);
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_PER   = 2'd2;
  localparam logic [CW-1:0] TMO_LAST = CW'(PER_TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [AW-1:0]     r_clr_idx;
  logic [CW-1:0]     r_cnt;
  logic              r_rsp_valid, r_rsp_err, r_rd_ram;
  logic [DATA_W-1:0] r_rsp_rdata, r_ram_q;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_clear, w_acc, w_aligned, w_per, w_ram, w_is_per, w_is_ram, w_ram_rd, w_ram_err;
  logic [AW-1:0]     w_idx, w_wr_idx;
  logic [NB-1:0]     w_wr_en;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_unused;

  assign w_clear    = r_state == S_CLEAR;
  assign clear_busy = w_clear;
  assign req_ready  = r_state == S_IDLE && !clear_start;
  assign w_acc      = req_valid && req_ready;
  assign w_aligned  = req_addr[1:0] == 2'b00;
  assign w_per      = req_addr[30:28] == PER_SEL;
  assign w_ram      = !req_addr[30] && req_addr[29:AW+2] == '0;
  assign w_is_per   = w_aligned && w_per;
  assign w_is_ram   = w_aligned && w_ram && !w_per;
  assign w_idx      = req_addr[AW+1:2];
  assign w_ram_rd   = w_acc && w_is_ram && !req_we;
  assign w_wr_en    = w_clear ? '1 : (w_acc && w_is_ram && req_we) ? req_be : '0;
  assign w_wr_idx   = w_clear ? r_clr_idx : w_idx;
  assign w_wr_data  = w_clear ? '0 : req_wdata;
  assign w_unused   = req_addr[31];

  // No reset on the array and a read-first registered port so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (w_wr_en[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
    if (w_ram_rd) r_ram_q <= r_mem[w_idx];
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] r_par_q, w_wr_par, w_par_bad;
  for (genvar g = 0; g < NB; g++) begin : g_par
    assign w_wr_par[g]  = !w_clear && (^req_wdata[8*g +: 8] ^ par_inject);
    assign w_par_bad[g] = ^r_ram_q[8*g +: 8] ^ r_par_q[g];
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (w_wr_en[b]) r_par[w_wr_idx][b] <= w_wr_par[b];
    if (w_ram_rd) r_par_q <= r_par[w_idx];
  end
  assign w_ram_err = r_rd_ram && |w_par_bad;
`else
  assign w_ram_err = 1'b0;
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rd_ram ? r_ram_q : r_rsp_rdata;
  assign rsp_err   = r_rsp_err || w_ram_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_clr_idx   <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_ram    <= 1'b0;
      r_rsp_rdata <= '0;
      per_req     <= 1'b0;
      per_we      <= 1'b0;
      per_be      <= '0;
      per_addr    <= '0;
      per_wdata   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_ram    <= 1'b0;
      r_rsp_rdata <= '0;
      if (r_state == S_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
        if (r_clr_idx == AW'(DEPTH - 1)) r_state <= S_IDLE;
      end else if (r_state == S_IDLE) begin
        if (clear_start) begin
          r_state   <= S_CLEAR;
          r_clr_idx <= '0;
        end else if (w_acc && w_is_per) begin
          per_req   <= 1'b1;
          per_we    <= req_we;
          per_be    <= req_be;
          per_addr  <= req_addr;
          per_wdata <= req_wdata;
          r_cnt     <= '0;
          r_state   <= S_PER;
        end else if (w_acc) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= !w_is_ram;
          r_rd_ram    <= w_ram_rd;
        end
      end else if (per_ack || r_cnt == TMO_LAST) begin
        per_req     <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= !per_ack;
        r_rsp_rdata <= (per_ack && !per_we) ? per_rdata : '0;
        r_state     <= S_IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl RAM, error, peripheral and clear behaviour.
module tb_dmem_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, clear_start = 1'b0, per_ack = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, per_rdata = '0;
  logic        req_ready, rsp_valid, rsp_err, clear_busy, per_req, per_we;
  logic [3:0]  per_be;
  logic [31:0] rsp_rdata, per_addr, per_wdata;
`ifdef DMEM_PARITY_EN
  logic        par_inject = 1'b0;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_PARITY_EN
    .par_inject(par_inject),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .per_req(per_req), .per_we(per_we), .per_be(per_be), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd,
                      output logic v, output logic [31:0] rd, output logic e);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    v = rsp_valid; rd = rsp_rdata; e = rsp_err;
  endtask

  task automatic clear_len(input int poke_at, output int n);
    n = 0;
    while (clear_busy && n < 2000) begin
      clear_start = (n == poke_at);
      step();
      n++;
    end
    clear_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic v, e;
    logic [31:0] rd;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_clear_busy", clear_busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_per_req", per_req, 0);
    reset = 1'b0;
    clear_len(-1, n);
    chk("rst_clear_len", n, 512);
    chk("idle_ready", req_ready, 1);
    xfer(0, 4'h0, 32'h10, 0, v, rd, e);
    chk("rd10_valid", v, 1); chk("rd10_data", rd, 0); chk("rd10_err", e, 0);
    xfer(1, 4'hF, 32'h20, 32'hDEADBEEF, v, rd, e);
    chk("wr20_valid", v, 1); chk("wr20_data", rd, 0); chk("wr20_err", e, 0);
    xfer(1, 4'h1, 32'h20, 32'h000000AA, v, rd, e);
    xfer(0, 4'h0, 32'h20, 0, v, rd, e);
    chk("be_valid", v, 1); chk("be_data", rd, 32'hDEADBEAA);
    step();
    chk("rsp_one_cycle", rsp_valid, 0);
    // Back-to-back read, write, read with no bubbles.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    step();
    chk("b2b_rd1_valid", rsp_valid, 1); chk("b2b_rd1_data", rsp_rdata, 0); chk("b2b_ready", req_ready, 1);
    req_we = 1'b1; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
    step();
    chk("b2b_wr_valid", rsp_valid, 1); chk("b2b_wr_data", rsp_rdata, 0);
    req_we = 1'b0; req_be = '0;
    step();
    req_valid = 1'b0;
    chk("b2b_rd2_valid", rsp_valid, 1); chk("b2b_rd2_data", rsp_rdata, 32'hCAFEF00D);
    xfer(1, 4'hF, 32'h7FC, 32'h600DF00D, v, rd, e);
    xfer(0, 4'h0, 32'h7FC, 0, v, rd, e);
    chk("top_word_data", rd, 32'h600DF00D); chk("top_word_err", e, 0);
    // Peripheral read acked after three wait cycles.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40000008;
    step();
    req_valid = 1'b0;
    chk("per_req_set", per_req, 1); chk("per_addr", per_addr, 32'h40000008); chk("per_we_rd", per_we, 0);
    chk("per_busy_ready", req_ready, 0); chk("per_no_rsp", rsp_valid, 0);
    repeat (3) step();
    chk("per_req_held", per_req, 1);
    per_ack = 1'b1; per_rdata = 32'h12345678;
    step();
    per_ack = 1'b0; per_rdata = '0;
    chk("per_rd_valid", rsp_valid, 1); chk("per_rd_data", rsp_rdata, 32'h12345678);
    chk("per_rd_err", rsp_err, 0); chk("per_rd_req_drop", per_req, 0);
    // Peripheral write acked immediately.
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0110; req_addr = 32'h40000100; req_wdata = 32'hA5A55A5A;
    step();
    req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    chk("per_wr_we", per_we, 1); chk("per_wr_be", per_be, 4'b0110); chk("per_wr_wdata", per_wdata, 32'hA5A55A5A);
    per_ack = 1'b1; per_rdata = 32'hFFFFFFFF;
    step();
    per_ack = 1'b0; per_rdata = '0;
    chk("per_wr_valid", rsp_valid, 1); chk("per_wr_data", rsp_rdata, 0); chk("per_wr_err", rsp_err, 0);
    // Peripheral timeout, then a late ack in IDLE.
    req_valid = 1'b1; req_addr = 32'h40000010;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    chk("to_len", n, 16); chk("to_err", rsp_err, 1); chk("to_data", rsp_rdata, 0);
    chk("to_per_req", per_req, 0); chk("to_ready", req_ready, 1);
    per_ack = 1'b1;
    step();
    per_ack = 1'b0;
    chk("late_ack_valid", rsp_valid, 0);
    // Error accesses leave RAM untouched.
    xfer(0, 4'h0, 32'h802, 0, v, rd, e);
    chk("mis_rd_valid", v, 1); chk("mis_rd_err", e, 1); chk("mis_rd_data", rd, 0);
    xfer(1, 4'hF, 32'h20000000, 32'hFFFFFFFF, v, rd, e);
    chk("oor_wr_valid", v, 1); chk("oor_wr_err", e, 1); chk("oor_per_req", per_req, 0);
    xfer(1, 4'hF, 32'h22, 32'h11111111, v, rd, e);
    chk("mis_wr_err", e, 1);
    xfer(0, 4'h0, 32'h800, 0, v, rd, e);
    chk("oor_rd_err", e, 1);
    xfer(0, 4'h0, 32'h0, 0, v, rd, e);
    chk("oor_alias_data", rd, 0); chk("oor_alias_err", e, 0);
    xfer(0, 4'h0, 32'h20, 0, v, rd, e);
    chk("mis_wr_unchanged", rd, 32'hDEADBEAA);
    // clear_start beats a simultaneous request; a second pulse mid-clear is ignored.
    clear_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h44; req_wdata = 32'h11111111;
    #1;
    chk("clr_req_ready", req_ready, 0);
    step();
    clear_start = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    chk("clr_no_rsp", rsp_valid, 0); chk("clr_busy", clear_busy, 1);
    clear_len(100, n);
    chk("clr_len", n, 512);
    xfer(0, 4'h0, 32'h20, 0, v, rd, e); chk("clr_rd20", rd, 0);
    xfer(0, 4'h0, 32'h40, 0, v, rd, e); chk("clr_rd40", rd, 0);
    xfer(0, 4'h0, 32'h44, 0, v, rd, e); chk("clr_rd44", rd, 0);
    xfer(0, 4'h0, 32'h7FC, 0, v, rd, e); chk("clr_rd7fc", rd, 0);
    // Reset in the middle of a clear restarts it from index 0.
    xfer(1, 4'hF, 32'h7FC, 32'h99, v, rd, e);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (200) step();
    chk("mid_busy", clear_busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_per_addr", per_addr, 0); chk("mid_rst_busy", clear_busy, 1);
    @(negedge clk);
    reset = 1'b0;
    clear_len(-1, n);
    chk("mid_rst_len", n, 512);
    xfer(0, 4'h0, 32'h7FC, 0, v, rd, e);
    chk("mid_rst_rd7fc", rd, 0);
`ifdef DMEM_PARITY_EN
    par_inject = 1'b1;
    xfer(1, 4'hF, 32'h30, 32'h01020304, v, rd, e);
    par_inject = 1'b0;
    xfer(0, 4'h0, 32'h30, 0, v, rd, e);
    chk("par_bad_err", e, 1); chk("par_bad_data", rd, 32'h01020304);
    xfer(1, 4'hF, 32'h34, 32'h0F0F0F07, v, rd, e);
    xfer(0, 4'h0, 32'h34, 0, v, rd, e);
    chk("par_ok_err", e, 0); chk("par_ok_data", rd, 32'h0F0F0F07);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
